cuckoo_hash_table: RTL and testbench
====================================

# cuckoo_hash_table

Parametrised two-table cuckoo hash engine that stores KEY_W-bit keys for the blockchain datapath: transaction/block-hash membership and de-duplication. It accepts one INSERT, SEARCH or DELETE request at a time over a valid/ready handshake. Displacement ("kick") chains run as a cycle-per-kick state machine bounded by MAX_KICKS. Each completed request produces one response pulse carrying hit/fail status and the slot location.

## Interface
- KEY_W, default 32: key width in bits.
- DEPTH, default 16: entries per table, power of two, ≥ 4; IDX_W = log2(DEPTH).
- MAX_KICKS, default 8: maximum evictions per INSERT before failure.
- clk  in  1: single clock, all logic on rising edge.
- rst  in  1: reset, synchronous, active-high.
- req_valid  in  1: request present.
- req_ready  out  1: engine idle and able to accept.
- req_op  in  2: 0 = SEARCH, 1 = INSERT, 2 = DELETE, 3 = reserved (treated as SEARCH).
- req_key  in  KEY_W: key operand.
- rsp_valid  out  1: one-cycle response pulse; no backpressure.
- rsp_hit  out  1: key was present before the operation.
- rsp_fail  out  1: INSERT could not place a key.
- rsp_key  out  KEY_W: on fail, the homeless key; otherwise the request key.
- rsp_table  out  1: table holding the key (0 = T1, 1 = T2). Valid when hit, or on a successful insert.
- rsp_index  out  IDX_W: slot index matching rsp_table.
- occupancy  out  IDX_W+2: number of valid entries across T1, T2 and the stash.

## Operation
- Hash functions: h1(k) = k[IDX_W-1:0]; h2(k) = (3·k mod 2^KEY_W)[IDX_W-1:0].
- Storage: register arrays T1/T2 of DEPTH keys, each entry with a valid bit. Reads are combinational.
- States:
  - IDLE: req_ready = 1. Accept when req_valid is high and go to LOOKUP with the key and op latched.
  - LOOKUP: compare the key against T1[h1] and T2[h2]; T1 has priority if both match. Then branch by op:
    - SEARCH: go to RESP.
    - DELETE on hit: clear that valid bit, decrement occupancy, go to RESP. On miss, go to RESP with no change.
    - INSERT on hit (duplicate): no write; go to RESP with rsp_hit = 1.
    - INSERT on miss: if T1[h1] is empty, write it. Otherwise, if T2[h2] is empty, write it. In both cases increment occupancy and go to RESP. If both are full, write the key into T1[h1], hold the evicted key as carry, set side = T2, set kicks = 1, and go to KICK.
  - KICK: one swap per cycle. Write carry into the side-table slot at its hash, take the old occupant as the new carry, and toggle side.
    - If the target slot was empty: increment occupancy and go to RESP with success.
    - If kicks == MAX_KICKS: go to RESP with rsp_fail = 1 and rsp_key = carry. The table contents stay permuted and occupancy is unchanged.
    - Otherwise increment kicks.
  - RESP: drive rsp_valid for one cycle, then return to IDLE.
- On successful insert, rsp_table/rsp_index report the original request key's slot. This is the T1[h1] slot if a kick chain started.
- The kick counter is wide enough to hold MAX_KICKS; it does not wrap.

## Timing
- Reset: state IDLE, all valid bits 0, occupancy 0, req_ready 1. rsp_valid, rsp_hit and rsp_fail are 0; rsp_key, rsp_table and rsp_index are 0.
- If rst is asserted mid-operation, it aborts on the next edge. No response is issued for the aborted request and the table is cleared.
- Latency, from the accept edge to rsp_valid high:
  - SEARCH, DELETE, duplicate INSERT and direct INSERT: 2 cycles.
  - INSERT with n kicks: 2 + n cycles.
  - Failed INSERT: 2 + MAX_KICKS cycles.
- req_ready is low from the accept edge until the cycle after RESP. A req_valid asserted while req_ready is low is ignored and must be held by the source.
- Response fields are valid only while rsp_valid = 1. They hold their last value otherwise.

## Configuration
- CUCKOO_STASH_EN defined: adds a one-entry stash.
  - A failed kick chain writes the carry into an empty stash and reports success with rsp_table = 1, rsp_index = all-ones, and occupancy incremented.
  - If the stash is already occupied, the insert fails as usual.
  - LOOKUP also compares against the stash for hit/duplicate/DELETE, at the same latency.
- CUCKOO_STASH_EN undefined: no stash logic; failure behaviour is as in Operation.

## Structure
- Package cuckoo_pkg holds:
  - op encodings: OP_SEARCH, OP_INSERT, OP_DELETE;
  - the state enum: IDLE, LOOKUP, KICK, RESP;
  - the default parameter constants.
- Sub-module cuckoo_hash: combinational; maps key to h1 and h2. It is instantiated twice, once for the request key and once for the carry key.

## Test plan
- After reset, SEARCH 42 (DEPTH=16): rsp_hit = 0 at accept+2 and occupancy = 0.
- INSERT 5, then SEARCH 5 → INSERT response {table 0, index 5}; search hit {0, 5}; occupancy = 1.
- INSERT 5, then INSERT 21 (h1 = 5, h2 = 15) → 21 goes to {table 1, index 15}. Re-INSERT 21 → rsp_hit = 1 and occupancy stays 2.
- INSERT 5, 21, then 37 (h1 = 5, h2 = 15), MAX_KICKS = 8 → at accept+10, rsp_fail = 1, rsp_key ∈ {5, 21, 37} and occupancy = 2. With CUCKOO_STASH_EN: success, index = 15 (all-ones for DEPTH = 16), occupancy = 3.
- DELETE 21 after the previous case → rsp_hit = 1 and occupancy decrements. A following SEARCH 21 → hit = 0.
- Assert rst during the KICK state of the 37 insert → no rsp_valid, req_ready = 1 next cycle, occupancy = 0, and SEARCH 5 misses.

Source files
------------

// File: rtl/cuckoo_pkg.sv
// Shared encodings and defaults for the two-table cuckoo hash engine.
package cuckoo_pkg;
   localparam int DEF_KEY_W     = 32;
   localparam int DEF_DEPTH     = 16;
   localparam int DEF_MAX_KICKS = 8;

   localparam logic [1:0] OP_SEARCH = 2'd0;
   localparam logic [1:0] OP_INSERT = 2'd1;
   localparam logic [1:0] OP_DELETE = 2'd2;

   typedef enum logic [1:0] {IDLE, LOOKUP, KICK, RESP} state_t;
endpackage

// File: rtl/cuckoo_hash_table_if.sv
// Request/response bus of the cuckoo hash engine; the engine is the slave.
interface cuckoo_hash_table_if #(
   parameter int KEY_W = 32,
   parameter int IDX_W = 4
);
   logic             req_valid;
   logic             req_ready;
   logic [1:0]       req_op;
   logic [KEY_W-1:0] req_key;
   logic             rsp_valid;
   logic             rsp_hit;
   logic             rsp_fail;
   logic [KEY_W-1:0] rsp_key;
   logic             rsp_table;
   logic [IDX_W-1:0] rsp_index;

   modport master (output req_valid, req_op, req_key,
                   input  req_ready, rsp_valid, rsp_hit, rsp_fail, rsp_key, rsp_table, rsp_index);
   modport slave  (input  req_valid, req_op, req_key,
                   output req_ready, rsp_valid, rsp_hit, rsp_fail, rsp_key, rsp_table, rsp_index);
endinterface

// File: rtl/cuckoo_hash.sv
// Combinational slot hashes: h1 = low key bits, h2 = low bits of 3*key.
module cuckoo_hash #(
   parameter int KEY_W = 32,
   parameter int IDX_W = 4
)(
   input  logic [KEY_W-1:0] key,
   output logic [IDX_W-1:0] h1,
   output logic [IDX_W-1:0] h2
);
   logic [KEY_W-1:0] k3;

   assign k3 = key + {key[KEY_W-2:0], 1'b0};
   assign h1 = key[IDX_W-1:0];
   assign h2 = k3[IDX_W-1:0];
endmodule

// File: rtl/cuckoo_hash_table.sv
// Two-table cuckoo hash engine with a bounded cycle-per-kick displacement chain.
// Optional one-entry overflow stash enabled by defining CUCKOO_STASH_EN.
module cuckoo_hash_table import cuckoo_pkg::*; #(
   parameter int KEY_W     = DEF_KEY_W,
   parameter int DEPTH     = DEF_DEPTH,
   parameter int MAX_KICKS = DEF_MAX_KICKS,
   localparam int IDX_W    = $clog2(DEPTH),
   localparam int KC_W     = $clog2(MAX_KICKS + 1)
)(
   input  logic              clk,
   input  logic              rst,
   cuckoo_hash_table_if.slave bus,
   output logic [IDX_W+1:0]  occupancy
);
   localparam logic [IDX_W+1:0] OCC_ONE = 1;
   localparam logic [KC_W-1:0]  KC_ONE  = 1;

   state_t                       state, state_n;
   logic [1:0]                   op;
   logic [KEY_W-1:0]             key, carry;
   logic                         side;
   logic [KC_W-1:0]              kicks;
   logic [DEPTH-1:0]             v1, v2;
   logic [DEPTH-1:0][KEY_W-1:0]  t1, t2;

   logic [IDX_W-1:0] kh1, kh2, ch1, ch2, kidx;
   logic             hit1, hit2, hits, any_hit, kocc, kick_last;
   logic [KEY_W-1:0] kold;

   logic             ld, n_hit, n_fail, n_table;
   logic [KEY_W-1:0] n_key;
   logic [IDX_W-1:0] n_index;
   logic             r_hit, r_fail, r_table;
   logic [KEY_W-1:0] r_key;
   logic [IDX_W-1:0] r_index;

   cuckoo_hash #(.KEY_W(KEY_W), .IDX_W(IDX_W)) u_hk (.key(key),   .h1(kh1), .h2(kh2));
   cuckoo_hash #(.KEY_W(KEY_W), .IDX_W(IDX_W)) u_hc (.key(carry), .h1(ch1), .h2(ch2));

`ifdef CUCKOO_STASH_EN
   logic             stash_v;
   logic [KEY_W-1:0] stash_k;
   assign hits = stash_v && (stash_k == key);
`else
   assign hits = 1'b0;
`endif

   assign hit1      = v1[kh1] && (t1[kh1] == key);
   assign hit2      = v2[kh2] && (t2[kh2] == key);
   assign any_hit   = hit1 || hit2 || hits;
   // side = 1 means the carry is headed for T2
   assign kidx      = side ? ch2 : ch1;
   assign kocc      = side ? v2[kidx] : v1[kidx];
   assign kold      = side ? t2[kidx] : t1[kidx];
   assign kick_last = (kicks == KC_W'(MAX_KICKS));

   always_comb begin
      state_n = state;
      ld      = 1'b0;
      n_hit   = 1'b0;
      n_fail  = 1'b0;
      n_key   = key;
      n_table = 1'b0;
      n_index = '0;
      case (state)
         IDLE: if (bus.req_valid) state_n = LOOKUP;
         LOOKUP: begin
            n_hit = any_hit;
            if (hit1) begin
               n_index = kh1;
            end else if (hit2) begin
               n_table = 1'b1;
               n_index = kh2;
            end else if (hits) begin
               n_table = 1'b1;
               n_index = '1;
            end else if (op == OP_INSERT && v1[kh1] && !v2[kh2]) begin
               n_table = 1'b1;
               n_index = kh2;
            end else begin
               n_index = kh1;
            end
            if (op == OP_INSERT && !any_hit && v1[kh1] && v2[kh2]) begin
               state_n = KICK;
            end else begin
               state_n = RESP;
               ld      = 1'b1;
            end
         end
         KICK: begin
            // a completed chain reports the request key's original T1 slot
            n_index = kh1;
            if (!kocc) begin
               state_n = RESP;
               ld      = 1'b1;
            end else if (kick_last) begin
               state_n = RESP;
               ld      = 1'b1;
`ifdef CUCKOO_STASH_EN
               if (stash_v) begin
                  n_fail = 1'b1;
                  n_key  = kold;
               end else begin
                  n_table = 1'b1;
                  n_index = '1;
               end
`else
               n_fail = 1'b1;
               n_key  = kold;
`endif
            end
         end
         RESP:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         op        <= OP_SEARCH;
         key       <= '0;
         carry     <= '0;
         side      <= 1'b0;
         kicks     <= '0;
         v1        <= '0;
         v2        <= '0;
         occupancy <= '0;
         r_hit     <= 1'b0;
         r_fail    <= 1'b0;
         r_key     <= '0;
         r_table   <= 1'b0;
         r_index   <= '0;
`ifdef CUCKOO_STASH_EN
         stash_v   <= 1'b0;
         stash_k   <= '0;
`endif
      end else begin
         state <= state_n;
         if (ld) begin
            r_hit   <= n_hit;
            r_fail  <= n_fail;
            r_key   <= n_key;
            r_table <= n_table;
            r_index <= n_index;
         end
         case (state)
            IDLE: if (bus.req_valid) begin
               op  <= bus.req_op;
               key <= bus.req_key;
            end
            LOOKUP: begin
               if (op == OP_DELETE) begin
                  if (hit1)      v1[kh1] <= 1'b0;
                  else if (hit2) v2[kh2] <= 1'b0;
`ifdef CUCKOO_STASH_EN
                  else if (hits) stash_v <= 1'b0;
`endif
                  if (any_hit) occupancy <= occupancy - OCC_ONE;
               end else if (op == OP_INSERT && !any_hit) begin
                  if (!v1[kh1]) begin
                     t1[kh1]   <= key;
                     v1[kh1]   <= 1'b1;
                     occupancy <= occupancy + OCC_ONE;
                  end else if (!v2[kh2]) begin
                     t2[kh2]   <= key;
                     v2[kh2]   <= 1'b1;
                     occupancy <= occupancy + OCC_ONE;
                  end else begin
                     t1[kh1] <= key;
                     carry   <= t1[kh1];
                     side    <= 1'b1;
                     kicks   <= KC_ONE;
                  end
               end
            end
            KICK: begin
               if (side) begin
                  t2[kidx] <= carry;
                  v2[kidx] <= 1'b1;
               end else begin
                  t1[kidx] <= carry;
                  v1[kidx] <= 1'b1;
               end
               carry <= kold;
               side  <= ~side;
               if (!kocc) begin
                  occupancy <= occupancy + OCC_ONE;
               end else if (kick_last) begin
`ifdef CUCKOO_STASH_EN
                  if (!stash_v) begin
                     stash_k   <= kold;
                     stash_v   <= 1'b1;
                     occupancy <= occupancy + OCC_ONE;
                  end
`endif
               end else begin
                  kicks <= kicks + KC_ONE;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.req_ready = (state == IDLE);
   assign bus.rsp_valid = (state == RESP);
   assign bus.rsp_hit   = r_hit;
   assign bus.rsp_fail  = r_fail;
   assign bus.rsp_key   = r_key;
   assign bus.rsp_table = r_table;
   assign bus.rsp_index = r_index;
endmodule

// File: tb/tb_cuckoo_hash_table.sv
// Directed vector bench for cuckoo_hash_table (DEPTH=16, MAX_KICKS=8); CUCKOO_STASH_EN aware.
module tb_cuckoo_hash_table;
   import cuckoo_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] occ;
   int         checks = 0;
   int         errors = 0;

   cuckoo_hash_table_if #(.KEY_W(32), .IDX_W(4)) bus ();

   cuckoo_hash_table #(.KEY_W(32), .DEPTH(16), .MAX_KICKS(8)) dut (
      .clk(clk), .rst(rst), .bus(bus), .occupancy(occ)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] key;
      logic        hit;
      logic        fail;
      logic [31:0] rkey;
      logic        loc;
      logic        tbl;
      logic [3:0]  idx;
      logic [5:0]  occ;
      int          lat;
   } vec_t;

   vec_t v [13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Issue one request from a negedge; returns accept-to-rsp_valid latency or -1 on timeout.
   task automatic issue(input logic [1:0] op, input logic [31:0] k, output int lat);
      int n;
      n = 0;
      while (!bus.req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_key   = k;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      lat = 1;
      while (!bus.rsp_valid && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      if (!bus.rsp_valid) lat = -1;
   endtask

   initial begin
      int lat;
      bit seen;

      v[0]  = '{OP_SEARCH, 42, 0, 0, 42, 0, 0, 0,  0, 2};
      v[1]  = '{OP_INSERT,  5, 0, 0,  5, 1, 0, 5,  1, 2};
      v[2]  = '{OP_SEARCH,  5, 1, 0,  5, 1, 0, 5,  1, 2};
      v[3]  = '{OP_INSERT, 21, 0, 0, 21, 1, 1, 15, 2, 2};
      v[4]  = '{OP_INSERT, 21, 1, 0, 21, 1, 1, 15, 2, 2};
`ifdef CUCKOO_STASH_EN
      v[5]  = '{OP_INSERT, 37, 0, 0, 37, 1, 1, 15, 3, 10};
      v[6]  = '{OP_DELETE, 21, 1, 0, 21, 1, 0, 5,  2, 2};
      v[7]  = '{OP_SEARCH, 21, 0, 0, 21, 0, 0, 0,  2, 2};
      v[8]  = '{OP_SEARCH,  5, 1, 0,  5, 1, 1, 15, 2, 2};
      v[9]  = '{OP_SEARCH, 37, 1, 0, 37, 1, 1, 15, 2, 2};
      v[10] = '{2'd3,       5, 1, 0,  5, 1, 1, 15, 2, 2};
      v[11] = '{OP_INSERT,  6, 0, 0,  6, 1, 0, 6,  3, 2};
      v[12] = '{OP_DELETE, 99, 0, 0, 99, 0, 0, 0,  3, 2};
`else
      v[5]  = '{OP_INSERT, 37, 0, 1, 37, 0, 0, 0,  2, 10};
      v[6]  = '{OP_DELETE, 21, 1, 0, 21, 1, 0, 5,  1, 2};
      v[7]  = '{OP_SEARCH, 21, 0, 0, 21, 0, 0, 0,  1, 2};
      v[8]  = '{OP_SEARCH,  5, 1, 0,  5, 1, 1, 15, 1, 2};
      v[9]  = '{OP_SEARCH, 37, 0, 0, 37, 0, 0, 0,  1, 2};
      v[10] = '{2'd3,       5, 1, 0,  5, 1, 1, 15, 1, 2};
      v[11] = '{OP_INSERT,  6, 0, 0,  6, 1, 0, 6,  2, 2};
      v[12] = '{OP_DELETE, 99, 0, 0, 99, 0, 0, 0,  2, 2};
`endif

      bus.req_valid = 1'b0;
      bus.req_op    = OP_SEARCH;
      bus.req_key   = '0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      chk("rst_ready",  32'(bus.req_ready), 1);
      chk("rst_valid",  32'(bus.rsp_valid), 0);
      chk("rst_hit",    32'(bus.rsp_hit),   0);
      chk("rst_fail",   32'(bus.rsp_fail),  0);
      chk("rst_key",    bus.rsp_key,        0);
      chk("rst_table",  32'(bus.rsp_table), 0);
      chk("rst_index",  32'(bus.rsp_index), 0);
      chk("rst_occ",    32'(occ),           0);

      for (int i = 0; i < 13; i++) begin
         issue(v[i].op, v[i].key, lat);
         chk($sformatf("v%0d_lat", i), lat, v[i].lat);
         if (lat >= 0) begin
            chk($sformatf("v%0d_hit", i),  32'(bus.rsp_hit),  32'(v[i].hit));
            chk($sformatf("v%0d_fail", i), 32'(bus.rsp_fail), 32'(v[i].fail));
            chk($sformatf("v%0d_key", i),  bus.rsp_key,       v[i].rkey);
            chk($sformatf("v%0d_occ", i),  32'(occ),          32'(v[i].occ));
            if (v[i].loc) begin
               chk($sformatf("v%0d_table", i), 32'(bus.rsp_table), 32'(v[i].tbl));
               chk($sformatf("v%0d_index", i), 32'(bus.rsp_index), 32'(v[i].idx));
            end
         end
      end

      // response is a single pulse and fields hold afterwards
      @(negedge clk);
      chk("pulse_low",  32'(bus.rsp_valid), 0);
      chk("hold_key",   bus.rsp_key,        99);
      chk("idle_ready", 32'(bus.req_ready), 1);

      // reset in the middle of a kick chain
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      issue(OP_INSERT, 5, lat);
      issue(OP_INSERT, 21, lat);
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_op    = OP_INSERT;
      bus.req_key   = 37;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      chk("busy_ready", 32'(bus.req_ready), 0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_ready", 32'(bus.req_ready), 1);
      chk("abort_occ",   32'(occ),           0);
      seen = 1'b0;
      for (int c = 0; c < 12; c++) begin
         if (bus.rsp_valid) seen = 1'b1;
         @(negedge clk);
      end
      chk("abort_norsp", 32'(seen), 0);
      issue(OP_SEARCH, 5, lat);
      chk("abort_lat", lat, 2);
      chk("abort_miss", 32'(bus.rsp_hit), 0);
      chk("abort_occ2", 32'(occ), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
